// File: rtl/err_pkg.sv
// Shared definitions for the error status unit and the frame parser:
// type-code constants, default sizing, and a one-hot decode helper.
package err_pkg;

  // Error type codes produced by the UART frame parser
  localparam int ERR_CMD  = 0;
  localparam int ERR_ADD  = 1;
  localparam int ERR_DATA = 2;

  // Default sizing
  localparam int NUM_ERR_DEF = 3;
  localparam int TYPE_W_DEF  = 2;
  localparam int CNT_W_DEF   = 8;

  // Decode helper works on a fixed-width code so it can be shared by
  // blocks with different TYPE_W; callers zero-extend and slice.
  localparam int CODE_W = 5;
  localparam int DEC_W  = 32;

  function automatic logic [DEC_W-1:0] err_onehot(input logic [CODE_W-1:0] code);
    logic [DEC_W-1:0] vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/err_sat_counter.sv
// Saturating event counter. Clear has priority over the current value,
// then the increment is applied, so clear+inc in one cycle yields 1.
module err_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, then increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end
    if (inc_i && (cnt_d != {CNT_W{1'b1}})) begin
      cnt_d = cnt_d + 1'b1;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/err_status_unit.sv
// Error status unit: decodes the parser's encoded error strobe into
// registered per-type pulses, sticky status, overflow flag, first-error
// capture, per-type saturating counters and a maskable interrupt.
// Clearing is write-1-to-clear via Clr_En/Clr_Mask; an event on the same
// type in the same cycle wins over the clear.
// Build option: define ERR_COUNTERS_EN to build the per-type counters;
// otherwise Err_Cnt is tied to zero with the same port list.
// Interface: no handshake; Err_En is a single-cycle strobe and every
// accepted event is absorbed in the cycle it is presented.
module err_status_unit #(
  parameter int NUM_ERR = err_pkg::NUM_ERR_DEF,
  parameter int TYPE_W  = err_pkg::TYPE_W_DEF,
  parameter int CNT_W   = err_pkg::CNT_W_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [TYPE_W-1:0]        Err_type,
  input  logic                     Err_En,
  input  logic                     Clr_En,
  input  logic [NUM_ERR-1:0]       Clr_Mask,
  input  logic [NUM_ERR-1:0]       Irq_Mask,
  output logic [NUM_ERR-1:0]       Err_Pulse,
  output logic [NUM_ERR-1:0]       Err_Sticky,
  output logic                     Err_Ovf,
  output logic [TYPE_W-1:0]        First_Err,
  output logic                     First_Vld,
  output logic [NUM_ERR*CNT_W-1:0] Err_Cnt,
  output logic                     Irq
);

  import err_pkg::*;

  // NUM_ERR always fits in TYPE_W+1 bits because 2**TYPE_W >= NUM_ERR
  localparam logic [TYPE_W:0] NUM_ERR_CODE = (TYPE_W+1)'(NUM_ERR);

  logic [NUM_ERR-1:0] pulse_q,  pulse_d;
  logic [NUM_ERR-1:0] sticky_q, sticky_d;
  logic               ovf_q,    ovf_d;
  logic [TYPE_W-1:0]  first_q,  first_d;
  logic               vld_q,    vld_d;

  logic               accept;
  logic [DEC_W-1:0]   ev_dec;
  logic [DEC_W-1:0]   first_dec;
  logic [NUM_ERR-1:0] ev_vec;
  logic [NUM_ERR-1:0] clr_vec;
  logic               clr_all;
  logic               first_clr;
  logic               unused_dec;

  // Codes at or above NUM_ERR are dropped like the old decoder's default arm
  assign accept    = Err_En && ({1'b0, Err_type} < NUM_ERR_CODE);
  assign ev_dec    = err_onehot(CODE_W'(Err_type));
  assign first_dec = err_onehot(CODE_W'(first_q));
  assign ev_vec    = accept ? ev_dec[NUM_ERR-1:0] : '0;
  assign clr_vec   = Clr_En ? Clr_Mask : '0;
  assign clr_all   = Clr_En && (&Clr_Mask);
  assign first_clr = vld_q && (|(clr_vec & first_dec[NUM_ERR-1:0]));
  assign unused_dec = ^{ev_dec[DEC_W-1:NUM_ERR], first_dec[DEC_W-1:NUM_ERR]};

  // Next-state for status: clear is applied first, then the event
  always_comb begin
    pulse_d  = ev_vec;
    sticky_d = (sticky_q & ~clr_vec) | ev_vec;
    ovf_d    = ovf_q;
    first_d  = first_q;
    vld_d    = vld_q;
    if (clr_all) begin
      ovf_d = 1'b0;
    end
    // Overflow only against sticky bits that survive this cycle's clear
    if (|(ev_vec & sticky_q & ~clr_vec)) begin
      ovf_d = 1'b1;
    end
    if (first_clr) begin
      vld_d   = 1'b0;
      first_d = '0;
    end
    if (accept && !vld_d) begin
      vld_d   = 1'b1;
      first_d = Err_type;
    end
  end

  // Status registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pulse_q  <= '0;
      sticky_q <= '0;
      ovf_q    <= 1'b0;
      first_q  <= '0;
      vld_q    <= 1'b0;
    end else begin
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      first_q  <= first_d;
      vld_q    <= vld_d;
    end
  end

`ifdef ERR_COUNTERS_EN
  for (genvar i = 0; i < NUM_ERR; i++) begin : g_cnt
    err_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i  (CLK),
      .rst_ni (RST),
      .inc_i  (ev_vec[i]),
      .clr_i  (clr_vec[i]),
      .cnt_o  (Err_Cnt[i*CNT_W +: CNT_W])
    );
  end
`else
  assign Err_Cnt = '0;
`endif

  assign Err_Pulse  = pulse_q;
  assign Err_Sticky = sticky_q;
  assign Err_Ovf    = ovf_q;
  assign First_Err  = first_q;
  assign First_Vld  = vld_q;
  assign Irq        = |(sticky_q & Irq_Mask);

endmodule

// File: doc/err_status_unit.md
Name: err_status_unit

Overview:
Parametrised successor to the bridge's combinational error decoder. Decodes an encoded error-type strobe from the UART frame parser into per-type registered pulses and sticky status bits. Keeps per-type saturating event counters and a first-error capture register, and drives a maskable interrupt. The APB-side control logic reads the block and clears it through a write-1-to-clear strobe.

Parameters:
NUM_ERR, 3, number of error types; type codes 0..NUM_ERR-1 (0=CMD, 1=ADD, 2=DATA by default).
TYPE_W, 2, width of Err_type; must satisfy 2**TYPE_W >= NUM_ERR.
CNT_W, 8, width of each per-type event counter.

Ports:
CLK  in  1  system clock; all logic on rising edge.
RST  in  1  synchronous, active-low reset.
Err_type  in  TYPE_W  encoded error type; sampled only when Err_En=1.
Err_En  in  1  error event strobe; one event per cycle at most.
Clr_En  in  1  clear strobe.
Clr_Mask  in  NUM_ERR  write-1-to-clear mask; qualified by Clr_En.
Irq_Mask  in  NUM_ERR  per-type interrupt enable; quasi-static.
Err_Pulse  out  NUM_ERR  one-hot, one-cycle registered pulse per accepted event.
Err_Sticky  out  NUM_ERR  sticky status bit per type.
Err_Ovf  out  1  sticky flag: an event hit a type whose sticky bit was already set.
First_Err  out  TYPE_W  type code of the first event since its last clear.
First_Vld  out  1  First_Err holds valid data.
Err_Cnt  out  NUM_ERR*CNT_W  packed counters; type i occupies bits [i*CNT_W +: CNT_W].
Irq  out  1  |(Err_Sticky & Irq_Mask).

Behaviour:
- Reset (RST=0 at a rising edge): all registered outputs go to 0, Irq=0. Reset overrides every other input, including mid-clear and mid-event.
- Accepted event: Err_En=1 and Err_type < NUM_ERR. Codes >= NUM_ERR are dropped with no state change, matching the decoder's default arm. Err_type is ignored when Err_En=0.
- Latency: for an event in cycle N, Err_Pulse[type], Err_Sticky[type] and the count increment are visible after edge N+1. Err_Pulse clears the following cycle unless another event arrives.
- Irq is combinational from registered Err_Sticky and Irq_Mask. It rises in the same cycle Err_Sticky rises.
- Err_Ovf: set when an accepted event's type already has Err_Sticky=1 before the edge. Cleared only when Clr_En=1 and Clr_Mask is all ones.
- Clear: when Clr_En=1, each bit with Clr_Mask[i]=1 clears Err_Sticky[i] and zeroes counter i.
- Clear and event on the same type in the same cycle: the event wins. Sticky ends at 1 and the counter ends at 1. No Err_Ovf is raised, because the sticky bit is treated as cleared first.
- Counters: increment by 1 per accepted event and saturate at 2**CNT_W-1. They never wrap.
- First-error capture: if First_Vld=0, an accepted event loads First_Err=type and sets First_Vld=1. Later events leave it unchanged.
- First_Vld clears when Clr_En=1 and Clr_Mask[First_Err]=1. If an accepted event occurs in that same cycle, that event is captured instead.
- No state machine beyond these per-type registers. There is no backpressure, so every accepted event is absorbed in one cycle.

Optional Feature:
ERR_COUNTERS_EN: when defined, the per-type saturating counters are built as described. When undefined, no counter flops are instantiated, Err_Cnt is tied to 0, and the port list is unchanged. All other behaviour is identical.

Decomposition:
- Package err_pkg holds:
  - the type-code constants ERR_CMD=0, ERR_ADD=1, ERR_DATA=2;
  - the default NUM_ERR, TYPE_W and CNT_W;
  - a one-hot decode function shared with the frame parser.
- One sub-module, err_sat_counter (CNT_W parameter, inc/clr inputs, clear-then-increment priority). It is instantiated NUM_ERR times in a generate loop.

Test Plan:
- Reset: hold RST=0 for 2 cycles with Err_En=1, Err_type=1 -> all outputs 0 throughout; after RST=1 and one idle cycle, outputs still 0.
- Basic decode: Err_En=1 with Err_type=0, then 1, then 2, on consecutive cycles ->
  - Err_Pulse = 001, 010, 100, each one cycle late;
  - Err_Sticky ends at 111;
  - First_Err=0, First_Vld=1;
  - each counter = 1.
- Illegal code: NUM_ERR=3, Err_Type=3 with Err_En=1 -> no pulse, sticky, counter or First_Vld change.
- Saturation and overflow: CNT_W=4, 20 events of type 2 -> Err_Cnt[2]=15; Err_Ovf=1 from the second event onward.
- Clear/event collision: with Err_Sticky=010 and count[1]=5, drive Clr_En=1, Clr_Mask=010 and an event of type 1 in the same cycle -> Err_Sticky=010, count[1]=1, Err_Ovf unchanged.
- Interrupt mask: with Irq_Mask=100, a type-0 event gives Irq=0; a following type-2 event gives Irq=1; Clr_Mask=100 with Clr_En=1 gives Irq=0 while Err_Sticky stays 001.
